v_issue_ctrl: RTL



---
 rtl/v_pkg.sv | 24 ++
 rtl/v_scoreboard.sv | 74 +++++++
 rtl/v_issue_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/v_pkg.sv
// Shared definitions for the vector issue controller: unit indices, FSM states
// and a one-hot helper for unit masks.
package v_pkg;

  localparam int NUM_UNITS  = 5;
  localparam int UNIT_IDX_W = 3;

  localparam int UNIT_ALU  = 0;
  localparam int UNIT_MUL  = 1;
  localparam int UNIT_RED  = 2;
  localparam int UNIT_SLDU = 3;
  localparam int UNIT_LSU  = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CFG   = 2'd2
  } state_t;

  function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [UNIT_IDX_W-1:0] u);
    return NUM_UNITS'(1) << u;
  endfunction

endpackage

// File: rtl/v_scoreboard.sv
// Register scoreboard: one pending bit per vector register plus the destination
// tag of the instruction in flight on each unit. Hazard query is combinational.
module v_scoreboard
  import v_pkg::*;
#(
  parameter int NUM_VREGS = 32,
  parameter int VREG_W    = $clog2(NUM_VREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic                  set_wr,
  input  logic [UNIT_IDX_W-1:0] set_unit,
  input  logic [VREG_W-1:0]     set_vd,
  input  logic [NUM_UNITS-1:0]  clr_units,
  input  logic                  rd_a_en,
  input  logic                  rd_b_en,
  input  logic [VREG_W-1:0]     q_vs1,
  input  logic [VREG_W-1:0]     q_vs2,
  input  logic [VREG_W-1:0]     q_vd,
  output logic                  hazard,
  output logic [NUM_VREGS-1:0]  pending
);

  logic [NUM_VREGS-1:0]                pending_reg;
  logic [NUM_VREGS-1:0]                pending_next;
  logic [NUM_VREGS-1:0]                set_bits;
  logic [NUM_VREGS-1:0]                clr_bits;
  logic [NUM_UNITS-1:0][NUM_VREGS-1:0] clr_vec;

  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      logic [VREG_W-1:0] tag_reg;
      // Stores keep a tag but never own a pending bit, so their done must not clear one.
      logic              tag_wr_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          tag_reg    <= '0;
          tag_wr_reg <= 1'b0;
        end else if (set_en && set_unit == UNIT_IDX_W'(gi)) begin
          tag_reg    <= set_vd;
          tag_wr_reg <= set_wr;
        end
      end

      assign clr_vec[gi] = (clr_units[gi] && tag_wr_reg) ? (NUM_VREGS'(1) << tag_reg) : '0;
    end
  endgenerate

  always_comb begin
    clr_bits = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      clr_bits = clr_bits | clr_vec[u];
    end
  end

  assign set_bits     = (set_en && set_wr) ? (NUM_VREGS'(1) << set_vd) : '0;
  assign pending_next = (pending_reg & ~clr_bits) | set_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign hazard  = (rd_a_en && pending_reg[q_vs1]) ||
                   (rd_b_en && pending_reg[q_vs2]) ||
                   pending_reg[q_vd];
  assign pending = pending_reg;

endmodule

// File: rtl/v_issue_ctrl.sv
// In-order vector issue controller: hazard check, one-cycle unit start pulses,
// completion tracking and serialised vconfig. Optional counters: V_ISSUE_STATS_EN.
module v_issue_ctrl
  import v_pkg::*;
#(
  parameter int NUM_VREGS = 32,
  parameter int VREG_W    = $clog2(NUM_VREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 is_vconfig,
  input  logic                 is_mul,
  input  logic                 is_vstype,
  input  logic [3:0]           v_alu_op,
  input  logic [2:0]           v_red_op,
  input  logic [2:0]           v_sldu_op,
  input  logic [3:0]           v_lsu_op,
  input  logic [2:0]           v_op_sel_A,
  input  logic [1:0]           v_op_sel_B,
  input  logic [VREG_W-1:0]    vd,
  input  logic [VREG_W-1:0]    vs1,
  input  logic [VREG_W-1:0]    vs2,
  input  logic [4:0]           unit_done,
  output logic [4:0]           unit_start,
  output logic [3:0]           iss_op,
  output logic [VREG_W-1:0]    iss_vd,
  output logic [VREG_W-1:0]    iss_vs1,
  output logic [VREG_W-1:0]    iss_vs2,
  output logic [2:0]           iss_sel_A,
  output logic [1:0]           iss_sel_B,
  output logic                 vcfg_wr,
  output logic [4:0]           unit_busy,
  output logic [NUM_VREGS-1:0] sb_pending
`ifdef V_ISSUE_STATS_EN
  ,
  output logic [31:0]          stat_issued,
  output logic [31:0]          stat_stall
`endif
);

  state_t                state_reg;
  logic                  tgt_valid;
  logic [UNIT_IDX_W-1:0] tgt_unit;
  logic [3:0]            tgt_op;
  logic                  is_cfg;
  logic                  sb_hazard;
  logic                  hazard;
  logic                  accept;
  logic                  issue;
  logic [4:0]            done_eff;

  // Fixed-priority unit decode; nothing selected means a NOP.
  always_comb begin
    tgt_valid = 1'b0;
    tgt_unit  = UNIT_IDX_W'(UNIT_ALU);
    tgt_op    = '0;
    is_cfg    = 1'b0;
    if (v_lsu_op != '0) begin
      tgt_valid = 1'b1;
      tgt_unit  = UNIT_IDX_W'(UNIT_LSU);
      tgt_op    = v_lsu_op;
    end else if (v_sldu_op != '0) begin
      tgt_valid = 1'b1;
      tgt_unit  = UNIT_IDX_W'(UNIT_SLDU);
      tgt_op    = {1'b0, v_sldu_op};
    end else if (v_red_op != '0) begin
      tgt_valid = 1'b1;
      tgt_unit  = UNIT_IDX_W'(UNIT_RED);
      tgt_op    = {1'b0, v_red_op};
    end else if (is_mul) begin
      tgt_valid = 1'b1;
      tgt_unit  = UNIT_IDX_W'(UNIT_MUL);
      tgt_op    = v_alu_op;
    end else if (v_alu_op != '0) begin
      tgt_valid = 1'b1;
      tgt_unit  = UNIT_IDX_W'(UNIT_ALU);
      tgt_op    = v_alu_op;
    end else if (is_vconfig) begin
      is_cfg = 1'b1;
    end
  end

  v_scoreboard #(
    .NUM_VREGS (NUM_VREGS),
    .VREG_W    (VREG_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue),
    .set_wr    (!is_vstype),
    .set_unit  (tgt_unit),
    .set_vd    (vd),
    .clr_units (done_eff),
    .rd_a_en   (v_op_sel_A == 3'd1),
    .rd_b_en   (v_op_sel_B == 2'd1),
    .q_vs1     (vs1),
    .q_vs2     (vs2),
    .q_vd      (vd),
    .hazard    (sb_hazard),
    .pending   (sb_pending)
  );

  // Busy comes from registered state only: a done and a re-issue to the same unit cost one cycle.
  assign hazard   = (tgt_valid && unit_busy[tgt_unit]) || sb_hazard;
  assign done_eff = unit_done & unit_busy;

  always_comb begin
    instr_ready = 1'b0;
    case (state_reg)
      ST_RUN:   instr_ready = instr_valid && !hazard && !is_cfg;
      ST_DRAIN: instr_ready = 1'b0;
      ST_CFG:   instr_ready = 1'b1;
      default:  instr_ready = 1'b0;
    endcase
  end

  assign accept = instr_valid && instr_ready;
  assign issue  = accept && (state_reg == ST_RUN) && tgt_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_RUN;
      unit_busy  <= '0;
      unit_start <= '0;
      vcfg_wr    <= 1'b0;
      iss_op     <= '0;
      iss_vd     <= '0;
      iss_vs1    <= '0;
      iss_vs2    <= '0;
      iss_sel_A  <= '0;
      iss_sel_B  <= '0;
    end else begin
      unit_start <= issue ? unit_onehot(tgt_unit) : '0;
      unit_busy  <= (unit_busy & ~done_eff) | (issue ? unit_onehot(tgt_unit) : '0);
      vcfg_wr    <= 1'b0;
      if (issue) begin
        iss_op    <= tgt_op;
        iss_vd    <= vd;
        iss_vs1   <= vs1;
        iss_vs2   <= vs2;
        iss_sel_A <= v_op_sel_A;
        iss_sel_B <= v_op_sel_B;
      end
      case (state_reg)
        ST_RUN:   if (instr_valid && is_cfg) state_reg <= ST_DRAIN;
        ST_DRAIN: if (unit_busy == '0) state_reg <= ST_CFG;
        ST_CFG: begin
          if (instr_valid) begin
            vcfg_wr   <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        default:  state_reg <= ST_RUN;
      endcase
    end
  end

`ifdef V_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (accept && (tgt_valid || is_cfg)) stat_issued <= stat_issued + 32'd1;
      if (instr_valid && !instr_ready)     stat_stall  <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
